arbitro_salida_2a1: RTL and testbench

- Shares one 16-bit output channel between two requesters, A and B.
- Each requester offers a word with a request/acknowledge handshake. The arbiter picks a winner, steers the 2:1 data selection and captures the chosen word into a one-entry output register.
- The output register drives a valid/ready consumer.
- Sits in front of the datapath's shared 16-bit bus, in place of a free-running select line.

---
 rtl/arbitro_salida_2a1.sv | 124 ++++++++++++
 tb/tb_arbitro_salida_2a1.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/arbitro_salida_2a1.sv
// Arbitrates two req/ack word sources onto one registered valid/ready output.
// Define ARB_PRIORIDAD_FIJA_EN for fixed priority to A; the default is round robin with burst limit.
module arbitro_salida_2a1 #(
  parameter int ANCHO      = 16,
  parameter int RAFAGA_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [ANCHO-1:0] dato_a,
  output logic             ack_a,
  input  logic             req_b,
  input  logic [ANCHO-1:0] dato_b,
  output logic             ack_b,
  output logic [ANCHO-1:0] salida,
  output logic             salida_valid,
  input  logic             salida_ready,
  output logic             sel,
  output logic             ocupado
);

  localparam int unsigned CW = $clog2(RAFAGA_MAX + 1);
  localparam logic [CW:0] LIMITE = (CW + 1)'(RAFAGA_MAX);

  typedef enum logic [1:0] {
    LIBRE  = 2'd0,
    SERV_A = 2'd1,
    SERV_B = 2'd2
  } estado_t;

  estado_t       estado, estado_sig;
  logic [CW-1:0] cuenta, cuenta_sig;
  logic          ultimo, ultimo_sig;  // 0 = A, 1 = B
  logic          hueco;
  logic          ack;
  logic          mio, otro, limite;
  logic [CW:0]   suma;

  assign hueco   = ~salida_valid | salida_ready;
  assign ack_a   = (estado == SERV_A) & req_a & hueco;
  assign ack_b   = (estado == SERV_B) & req_b & hueco;
  assign ack     = ack_a | ack_b;
  assign ocupado = (estado != LIBRE);
  // Burst count including the transfer happening at this edge.
  assign suma    = {1'b0, cuenta} + (CW + 1)'(ack);

  always_comb begin
    estado_sig = estado;
    cuenta_sig = cuenta;
    ultimo_sig = ultimo;
    mio        = (estado == SERV_A) ? req_a : req_b;
    otro       = (estado == SERV_A) ? req_b : req_a;
`ifdef ARB_PRIORIDAD_FIJA_EN
    // A holds the grant indefinitely; B yields right after its next word.
    limite     = (estado == SERV_B) & (ack_b | (suma >= LIMITE));
`else
    limite     = (suma >= LIMITE);
`endif
    case (estado)
      LIBRE: begin
`ifdef ARB_PRIORIDAD_FIJA_EN
        if (req_a) begin
`else
        if (req_a && (!req_b || ultimo)) begin
`endif
          estado_sig = SERV_A;
          cuenta_sig = '0;
          ultimo_sig = 1'b0;
        end else if (req_b) begin
          estado_sig = SERV_B;
          cuenta_sig = '0;
          ultimo_sig = 1'b1;
        end
      end
      SERV_A, SERV_B: begin
        // With the output register full nothing moves: no switch, no count.
        if (hueco) begin
          if (otro && (!mio || limite)) begin
            estado_sig = (estado == SERV_A) ? SERV_B : SERV_A;
            cuenta_sig = '0;
            ultimo_sig = (estado == SERV_A);
          end else if (!mio) begin
            estado_sig = LIBRE;
          end else if (suma > LIMITE) begin
            cuenta_sig = CW'(RAFAGA_MAX);
          end else begin
            cuenta_sig = suma[CW-1:0];
          end
        end
      end
      default: begin
        estado_sig = LIBRE;
        cuenta_sig = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= LIBRE;
      sel    <= 1'b0;
      cuenta <= '0;
      ultimo <= 1'b1;
    end else begin
      estado <= estado_sig;
      sel    <= (estado_sig == SERV_B);
      cuenta <= cuenta_sig;
      ultimo <= ultimo_sig;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      salida       <= '0;
      salida_valid <= 1'b0;
    end else if (ack) begin
      salida       <= sel ? dato_b : dato_a;
      salida_valid <= 1'b1;
    end else if (salida_ready) begin
      salida_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arbitro_salida_2a1.sv
// Directed bench for arbitro_salida_2a1: reset, contention, single source,
// backpressure, async reset mid-burst and (when the macro is set) fixed priority.
module tb_arbitro_salida_2a1;

  logic        clk;
  logic        rst_n;
  logic        req_a, req_b;
  logic [15:0] dato_a, dato_b;
  logic        ack_a, ack_b;
  logic [15:0] salida;
  logic        salida_valid;
  logic        salida_ready;
  logic        sel;
  logic        ocupado;

  int ncmp = 0;
  int nerr = 0;

  arbitro_salida_2a1 #(.ANCHO(16), .RAFAGA_MAX(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_a        (req_a),
    .dato_a       (dato_a),
    .ack_a        (ack_a),
    .req_b        (req_b),
    .dato_b       (dato_b),
    .ack_b        (ack_b),
    .salida       (salida),
    .salida_valid (salida_valid),
    .salida_ready (salida_ready),
    .sel          (sel),
    .ocupado      (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic paso();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic esel;
    logic psel;
    rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1;
    dato_a = 16'hAAAA; dato_b = 16'hBBBB; salida_ready = 1'b1;

    // Reset held with both requests high
    paso(); paso();
    chk("rst_sel", {31'd0, sel}, 32'd0);
    chk("rst_salida", {16'd0, salida}, 32'h0000);
    chk("rst_valid", {31'd0, salida_valid}, 32'd0);
    chk("rst_ack_a", {31'd0, ack_a}, 32'd0);
    chk("rst_ack_b", {31'd0, ack_b}, 32'd0);
    chk("rst_ocupado", {31'd0, ocupado}, 32'd0);

    // Contention: A wins the first tie, then 4/4 alternation without gaps
    rst_n = 1'b1;
    psel = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      paso();
      esel = (((k - 1) / 4) % 2) == 1;
      chk($sformatf("cont_sel_%0d", k), {31'd0, sel}, {31'd0, esel});
      chk($sformatf("cont_ack_a_%0d", k), {31'd0, ack_a}, {31'd0, ~esel});
      chk($sformatf("cont_ack_b_%0d", k), {31'd0, ack_b}, {31'd0, esel});
      if (k >= 2) begin
        chk($sformatf("cont_salida_%0d", k), {16'd0, salida}, psel ? 32'hBBBB : 32'hAAAA);
        chk($sformatf("cont_valid_%0d", k), {31'd0, salida_valid}, 32'd1);
      end
      psel = esel;
    end
    req_a = 1'b0; req_b = 1'b0;
    #1;
    chk("idle_ack_a", {31'd0, ack_a}, 32'd0);
    paso();
    chk("idle_ocupado", {31'd0, ocupado}, 32'd0);
    chk("idle_valid", {31'd0, salida_valid}, 32'd0);
    chk("idle_salida", {16'd0, salida}, 32'hAAAA);

    // Single requester, three consecutive words
    req_a = 1'b1; dato_a = 16'h1111;
    paso();
    chk("single_grant", {31'd0, ack_a}, 32'd1);
    chk("single_valid0", {31'd0, salida_valid}, 32'd0);
    paso();
    chk("single_w1", {16'd0, salida}, 32'h1111);
    chk("single_v1", {31'd0, salida_valid}, 32'd1);
    dato_a = 16'h2222;
    paso();
    chk("single_w2", {16'd0, salida}, 32'h2222);
    dato_a = 16'h3333;
    paso();
    chk("single_w3", {16'd0, salida}, 32'h3333);
    chk("single_v3", {31'd0, salida_valid}, 32'd1);
    req_a = 1'b0;
    paso();
    chk("single_vdrop", {31'd0, salida_valid}, 32'd0);
    chk("single_libre", {31'd0, ocupado}, 32'd0);
    chk("single_hold", {16'd0, salida}, 32'h3333);

    // Backpressure with a full output register
    salida_ready = 1'b0; req_a = 1'b1; dato_a = 16'h1111;
    paso();
    chk("bp_grant", {31'd0, ack_a}, 32'd1);
    paso();
    chk("bp_w1", {16'd0, salida}, 32'h1111);
    chk("bp_v1", {31'd0, salida_valid}, 32'd1);
    dato_a = 16'h2222;
    #1;
    chk("bp_noack", {31'd0, ack_a}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      paso();
      chk($sformatf("bp_stall_ack_%0d", k), {31'd0, ack_a}, 32'd0);
      chk($sformatf("bp_stall_salida_%0d", k), {16'd0, salida}, 32'h1111);
      chk($sformatf("bp_stall_valid_%0d", k), {31'd0, salida_valid}, 32'd1);
    end
    salida_ready = 1'b1;
    #1;
    chk("bp_release_ack", {31'd0, ack_a}, 32'd1);
    paso();
    chk("bp_same_edge_salida", {16'd0, salida}, 32'h2222);
    chk("bp_same_edge_valid", {31'd0, salida_valid}, 32'd1);

    // Asynchronous reset between edges with a word held
    dato_a = 16'h3333; salida_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, salida_valid}, 32'd0);
    chk("arst_salida", {16'd0, salida}, 32'h0000);
    chk("arst_ocupado", {31'd0, ocupado}, 32'd0);
    chk("arst_ack_a", {31'd0, ack_a}, 32'd0);
    req_a = 1'b0; salida_ready = 1'b1;
    paso();
    rst_n = 1'b1;
    paso(); paso();
    chk("arst_no_replay_valid", {31'd0, salida_valid}, 32'd0);
    chk("arst_no_replay_salida", {16'd0, salida}, 32'h0000);

`ifdef ARB_PRIORIDAD_FIJA_EN
    // Fixed priority: B bursting, A arrives -> one more B word, then A holds
    req_b = 1'b1; dato_b = 16'hBBBB;
    paso();
    chk("fija_sel_b", {31'd0, sel}, 32'd1);
    paso(); paso();
    req_a = 1'b1; dato_a = 16'hAAAA;
    #1;
    chk("fija_last_b_ack", {31'd0, ack_b}, 32'd1);
    chk("fija_a_wait", {31'd0, ack_a}, 32'd0);
    paso();
    chk("fija_last_b_word", {16'd0, salida}, 32'hBBBB);
    chk("fija_sel_a", {31'd0, sel}, 32'd0);
    chk("fija_ack_a", {31'd0, ack_a}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      paso();
      chk($sformatf("fija_hold_sel_%0d", k), {31'd0, sel}, 32'd0);
      chk($sformatf("fija_hold_salida_%0d", k), {16'd0, salida}, 32'hAAAA);
    end
    req_a = 1'b0;
    paso();
    chk("fija_back_to_b", {31'd0, sel}, 32'd1);
    req_b = 1'b0;
    paso();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
